hsv_axil_sram: RTL

HSV_AXIL_SRAM -- requirements
Module: hsv_axil_sram

---
 rtl/hsv_axil_sram_if.sv | 32 +++
 rtl/hsv_axil_sram.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hsv_axil_sram_if.sv
// AXI4-Lite bundle (32-bit address/data) shared by the core dmem initiator and its SRAM.
// Latency: none, wires only.
// Backpressure: plain valid/ready per channel; 's' is the responder view, 'm' the initiator view.
interface axil_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport s (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport m (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/hsv_axil_sram.sv
// Word-addressed AXI4-Lite SRAM responder for the core dmem port, independent read/write FSMs.
// Latency: B valid the cycle after the AW/W pair completes; R valid the cycle after AR.
// Backpressure: one outstanding write and one outstanding read; readies drop until B/R accepted.
// Ports: clk_core (single clock), rst_core_n (async active-low), dmem (axil_if.s responder).
// Addresses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) answer SLVERR and never touch memory.
module hsv_axil_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic clk_core,
  input  logic rst_core_n,
  axil_if.s    dmem
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_EXT = BASE_EXT + (33'(DEPTH_WORDS) << 2);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_RESP} r_state_t;

  // 33-bit compare so a window ending at 4 GiB cannot wrap around to zero.
  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= BASE_EXT) && ({1'b0, a} < LIMIT_EXT);
  endfunction

  w_state_t    w_state, w_state_nxt;
  r_state_t    r_state, r_state_nxt;
  logic        rdy_en;
  logic [31:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        b_err_q;
  logic        r_err_q;
  logic [31:0] mem_rd_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        aw_hs, w_hs, ar_hs;
  logic        wr_commit, mem_we;
  logic [31:0] w_addr_eff, w_data_eff;
  logic [3:0]  w_strb_eff;
  logic [31:0] w_off, r_off;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic        unused_off_bits;

  assign aw_hs = dmem.awvalid && dmem.awready;
  assign w_hs  = dmem.wvalid  && dmem.wready;
  assign ar_hs = dmem.arvalid && dmem.arready;

  // Whichever half arrived first was parked in a register; the other half is taken live.
  assign w_addr_eff = (w_state == W_HAVE_AW) ? awaddr_q : dmem.awaddr;
  assign w_data_eff = (w_state == W_HAVE_W)  ? wdata_q  : dmem.wdata;
  assign w_strb_eff = (w_state == W_HAVE_W)  ? wstrb_q  : dmem.wstrb;

  assign wr_commit = ((w_state == W_IDLE)    && aw_hs && w_hs) ||
                     ((w_state == W_HAVE_AW) && w_hs) ||
                     ((w_state == W_HAVE_W)  && aw_hs);
  assign mem_we    = wr_commit && in_range(w_addr_eff);

  assign w_off = w_addr_eff - BASE_ADDR;
  assign r_off = dmem.araddr - BASE_ADDR;
  assign w_idx = w_off[IDX_W+1:2];
  assign r_idx = r_off[IDX_W+1:2];
  assign unused_off_bits = ^{w_off[31:IDX_W+2], w_off[1:0], r_off[31:IDX_W+2], r_off[1:0]};

  // Holds readies low during reset and releases them at the first edge afterwards,
  // so readiness stays a pure function of registered state.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) rdy_en <= 1'b0;
    else             rdy_en <= 1'b1;
  end

  // State registers.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_nxt = W_RESP;
        else if (aw_hs)    w_state_nxt = W_HAVE_AW;
        else if (w_hs)     w_state_nxt = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)        w_state_nxt = W_RESP;
      W_HAVE_W:  if (aw_hs)       w_state_nxt = W_RESP;
      W_RESP:    if (dmem.bready) w_state_nxt = W_IDLE;
      default:                    w_state_nxt = W_IDLE;
    endcase

    r_state_nxt = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs)        r_state_nxt = R_RESP;
      R_RESP:  if (dmem.rready)  r_state_nxt = R_IDLE;
      default:                   r_state_nxt = R_IDLE;
    endcase
  end

  // Outputs, decoded from state and response registers only.
  always_comb begin
    dmem.awready = 1'b0;
    dmem.wready  = 1'b0;
    dmem.bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        dmem.awready = rdy_en;
        dmem.wready  = rdy_en;
      end
      W_HAVE_AW: dmem.wready  = 1'b1;
      W_HAVE_W:  dmem.awready = 1'b1;
      W_RESP:    dmem.bvalid  = 1'b1;
      default: ;
    endcase
    dmem.bresp   = (dmem.bvalid && b_err_q) ? 2'b10 : 2'b00;

    dmem.arready = (r_state == R_IDLE) && rdy_en;
    dmem.rvalid  = (r_state == R_RESP);
    dmem.rresp   = (dmem.rvalid && r_err_q) ? 2'b10 : 2'b00;
    dmem.rdata   = (dmem.rvalid && !r_err_q) ? mem_rd_q : 32'h0;
  end

  // Parked request halves and response status.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      awaddr_q <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'h0;
      b_err_q  <= 1'b0;
      r_err_q  <= 1'b0;
    end else begin
      if ((w_state == W_IDLE) && aw_hs) awaddr_q <= dmem.awaddr;
      if ((w_state == W_IDLE) && w_hs) begin
        wdata_q <= dmem.wdata;
        wstrb_q <= dmem.wstrb;
      end
      if (wr_commit) b_err_q <= !in_range(w_addr_eff);
      if (ar_hs)     r_err_q <= !in_range(dmem.araddr);
    end
  end

  // Storage: one byte-enabled write port, one registered read port, no reset.
  // Nonblocking semantics give old data when a read and a write hit the same word on one edge.
  always_ff @(posedge clk_core) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb_eff[i]) mem[w_idx][i*8 +: 8] <= w_data_eff[i*8 +: 8];
      end
    end
    if (ar_hs) mem_rd_q <= mem[r_idx];
  end

endmodule
